// File: rtl/filter_preload_loader.sv
// Wishbone classic read master that copies a filter (up to FILTER_WORDS words)
// from system RAM into a local tap buffer read by the SIMD MAC CFU.
module filter_preload_loader #(
    parameter int FILTER_WORDS = 32,
    parameter int MAX_RETRY    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_valid,
    output logic                          start_ready,
    input  logic [31:0]                   start_base_adr,
    input  logic [$clog2(FILTER_WORDS):0] start_len,
    output logic                          busy,
    output logic                          done,
    output logic                          load_err,
    output logic [$clog2(FILTER_WORDS):0] words_loaded,
    input  logic [$clog2(FILTER_WORDS)-1:0] rd_idx,
    output logic [31:0]                   rd_data,
    output logic                          rd_valid,
    output logic [29:0]                   cfu_ram_adr,
    output logic [31:0]                   cfu_ram_dat_mosi,
    output logic [3:0]                    cfu_ram_sel,
    output logic                          cfu_ram_cyc,
    output logic                          cfu_ram_stb,
    output logic                          cfu_ram_we,
    output logic [2:0]                    cfu_ram_cti,
    output logic [1:0]                    cfu_ram_bte,
    input  logic [31:0]                   cfu_ram_dat_miso,
    input  logic                          cfu_ram_ack,
    input  logic                          cfu_ram_err
);
    // state | meaning
    // IDLE  | waiting for a start command
    // FETCH | cyc/stb asserted for buffer[idx], waiting for ack/err
    // GAP   | one idle bus cycle between words
    // DONE  | one-cycle done pulse after a complete load
    // ABORT | one-cycle done pulse with load_err after too many errors
    localparam int LW = $clog2(FILTER_WORDS) + 1;
    localparam int IW = $clog2(FILTER_WORDS);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [LW-1:0] LP_FW   = LW'(FILTER_WORDS);
    localparam logic [RW-1:0] LP_MAXR = RW'(MAX_RETRY);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    logic [2:0]    r_state;
    logic [29:0]   r_adr;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_words;
    logic [IW-1:0] r_idx;
    logic [RW-1:0] r_retry;
    logic          r_err;
    logic [31:0]   r_buf [FILTER_WORDS];
    logic [31:0]   r_rd_data;
    logic          r_rd_valid;

    logic          w_fetch;
    logic          w_ack;
    logic          w_err;
    logic          w_last;
    logic [RW-1:0] w_retry_nxt;
    logic [LW-1:0] w_len_clamp;
    logic          w_unused;

    assign w_fetch     = (r_state == S_FETCH);
    assign w_ack       = w_fetch & cfu_ram_ack;
    // ack wins when the slave raises both terminations together
    assign w_err       = w_fetch & cfu_ram_err & ~cfu_ram_ack;
    assign w_last      = ({1'b0, r_idx} == (r_len - LW'(1)));
    assign w_retry_nxt = r_retry + RW'(1);
    assign w_len_clamp = (start_len > LP_FW) ? LP_FW : start_len;
    assign w_unused    = &{1'b0, start_base_adr[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_idx   <= '0;
            r_retry <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_adr   <= start_base_adr[31:2];
                        r_len   <= w_len_clamp;
                        r_idx   <= '0;
                        r_words <= '0;
                        r_retry <= '0;
                        r_err   <= 1'b0;
                        r_state <= (w_len_clamp == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_ack) begin
                        r_words <= {1'b0, r_idx} + LW'(1);
                        r_retry <= '0;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_adr   <= r_adr + 30'd1;
                            r_state <= S_GAP;
                        end
                    end else if (w_err) begin
                        r_retry <= w_retry_nxt;
                        if (w_retry_nxt == LP_MAXR) begin
                            r_err   <= 1'b1;
                            r_state <= S_ABORT;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP:   r_state <= S_FETCH;
                S_DONE:  r_state <= S_IDLE;
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer contents survive reset; only the valid count is cleared.
    always_ff @(posedge clk) begin
        if (w_ack) begin
            r_buf[r_idx] <= cfu_ram_dat_miso;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= r_buf[rd_idx];
            r_rd_valid <= ({1'b0, rd_idx} < r_words);
        end
    end

    assign start_ready      = (r_state == S_IDLE);
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE) | (r_state == S_ABORT);
    assign load_err         = r_err;
    assign words_loaded     = r_words;
    assign rd_data          = r_rd_data;
    assign rd_valid         = r_rd_valid;
    assign cfu_ram_adr      = r_adr;
    assign cfu_ram_dat_mosi = 32'd0;
    assign cfu_ram_sel      = 4'b1111;
    assign cfu_ram_cyc      = w_fetch;
    assign cfu_ram_stb      = w_fetch;
    assign cfu_ram_we       = 1'b0;
    assign cfu_ram_cti      = 3'd0;
    assign cfu_ram_bte      = 2'd0;

endmodule

// File: tb/tb_filter_preload_loader.sv
// Directed bench for filter_preload_loader: a Wishbone RAM model with
// programmable error/ack+err injection and a negedge monitor.
module tb_filter_preload_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] start_base_adr;
    logic [5:0]  start_len;
    logic        busy, done, load_err;
    logic [5:0]  words_loaded;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [29:0] adr;
    logic [31:0] dat_mosi;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_miso;
    logic        ack, err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    filter_preload_loader #(.FILTER_WORDS(32), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_base_adr(start_base_adr), .start_len(start_len),
        .busy(busy), .done(done), .load_err(load_err),
        .words_loaded(words_loaded),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
        .cfu_ram_adr(adr), .cfu_ram_dat_mosi(dat_mosi), .cfu_ram_sel(sel),
        .cfu_ram_cyc(cyc), .cfu_ram_stb(stb), .cfu_ram_we(we),
        .cfu_ram_cti(cti), .cfu_ram_bte(bte),
        .cfu_ram_dat_miso(dat_miso), .cfu_ram_ack(ack), .cfu_ram_err(err)
    );

    function automatic logic [31:0] ram_word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hC0DE_5A5A;
    endfunction

    // RAM slave: one wait state, optional error bursts on err_adr
    logic [29:0] err_adr  = 30'h3FFF_FFFF;
    logic [29:0] both_adr = 30'h3FFF_FFFF;
    int          err_n    = 0;
    int          err_used;

    always @(posedge clk) begin
        ack <= 1'b0;
        err <= 1'b0;
        if (!busy) err_used <= 0;
        if (cyc && stb && !ack && !err) begin
            dat_miso <= ram_word(adr);
            if (adr == err_adr && err_used < err_n) begin
                err      <= 1'b1;
                err_used <= err_used + 1;
            end else if (adr == both_adr) begin
                ack <= 1'b1;
                err <= 1'b1;
            end else begin
                ack <= 1'b1;
            end
        end
    end

    logic [29:0] ack_log[$];
    int   done_cnt, err_seen, err_bad_adr;
    logic cyc_seen;
    int   mon_gen = 0;
    int   mon_last = -1;

    always @(negedge clk) begin
        if (mon_gen != mon_last) begin
            mon_last    = mon_gen;
            ack_log.delete();
            done_cnt    = 0;
            err_seen    = 0;
            err_bad_adr = 0;
            cyc_seen    = 1'b0;
        end
        if (cyc) cyc_seen = 1'b1;
        if (done) done_cnt++;
        if (cyc && stb && ack) ack_log.push_back(adr);
        else if (cyc && stb && err) begin
            err_seen++;
            if (adr != err_adr) err_bad_adr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_gen++;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [31:0] base, input logic [5:0] len);
        @(negedge clk);
        start_base_adr = base;
        start_len      = len;
        start_valid    = 1'b1;
        @(negedge clk);
        start_valid    = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int k = 0;
        while (done !== 1'b1 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic read_chk(input int i, input logic [31:0] exp, input logic expv, input string tag);
        @(negedge clk);
        rd_idx = i[4:0];
        @(negedge clk);
        check({tag, " rd_valid"}, {31'd0, rd_valid}, {31'd0, expv});
        if (expv) check({tag, " rd_data"}, rd_data, exp);
    endtask

    task automatic log_chk(input logic [29:0] first, input int n, input string tag);
        check({tag, " ack count"}, ack_log.size(), n);
        for (int i = 0; i < n && i < ack_log.size(); i++)
            check({tag, " ack adr"}, {2'b0, ack_log[i]}, {2'b0, first + 30'(i)});
    endtask

    initial begin
        reset          = 1'b0;
        start_valid    = 1'b0;
        start_base_adr = '0;
        start_len      = '0;
        rd_idx         = '0;
        repeat (2) @(negedge clk);
        check("rst cyc", {31'd0, cyc}, 0);
        check("rst stb", {31'd0, stb}, 0);
        check("rst busy", {31'd0, busy}, 0);
        check("rst done", {31'd0, done}, 0);
        check("rst load_err", {31'd0, load_err}, 0);
        check("rst words", {26'd0, words_loaded}, 0);
        check("rst adr", {2'd0, adr}, 0);
        check("rst rd_valid", {31'd0, rd_valid}, 0);
        check("rst rd_data", rd_data, 0);
        check("rst ready", {31'd0, start_ready}, 1);
        check("tie sel/we/cti/bte", {22'd0, sel, we, cti, bte}, {22'd0, 4'hF, 1'b0, 3'd0, 2'd0});
        reset = 1'b1;
        clear_mon();

        // 1: four words from 0x1000
        do_start(32'h0000_1000, 6'd4);
        check("t1 cyc first", {31'd0, cyc & stb}, 1);
        check("t1 adr first", {2'd0, adr}, 32'h400);
        check("t1 busy", {31'd0, busy}, 1);
        wait_done(40, "t1");
        check("t1 words", {26'd0, words_loaded}, 4);
        check("t1 load_err", {31'd0, load_err}, 0);
        @(negedge clk);
        check("t1 done pulse", {31'd0, done}, 0);
        check("t1 idle", {31'd0, busy}, 0);
        log_chk(30'h400, 4, "t1");
        check("t1 done count", done_cnt, 1);
        for (int i = 0; i < 4; i++) read_chk(i, ram_word(30'h400 + 30'(i)), 1'b1, "t1 buf");
        read_chk(4, 32'd0, 1'b0, "t1 past end");

        // 2: zero-length load
        clear_mon();
        do_start(32'h0000_2000, 6'd0);
        check("t2 done", {31'd0, done}, 1);
        @(negedge clk);
        check("t2 done pulse", {31'd0, done}, 0);
        check("t2 ready", {31'd0, start_ready}, 1);
        check("t2 words", {26'd0, words_loaded}, 0);
        repeat (2) @(negedge clk);
        check("t2 no cyc", {31'd0, cyc_seen}, 0);
        check("t2 done count", done_cnt, 1);

        // 3: length clamped to buffer depth
        clear_mon();
        do_start(32'h0000_2000, 6'd40);
        wait_done(200, "t3");
        check("t3 words", {26'd0, words_loaded}, 32);
        @(negedge clk);
        log_chk(30'h800, 32, "t3");
        if (ack_log.size() > 0) check("t3 last adr", {2'd0, ack_log[ack_log.size()-1]}, 32'h81F);
        read_chk(31, ram_word(30'h81F), 1'b1, "t3 buf31");

        // 4a: two errors on word 2, then success
        clear_mon();
        err_adr = 30'hC02;
        err_n   = 2;
        do_start(32'h0000_3000, 6'd4);
        wait_done(60, "t4a");
        check("t4a words", {26'd0, words_loaded}, 4);
        check("t4a load_err", {31'd0, load_err}, 0);
        @(negedge clk);
        check("t4a err seen", err_seen, 2);
        check("t4a err adr", err_bad_adr, 0);
        log_chk(30'hC00, 4, "t4a");

        // 4b: three errors on word 2 abort the load
        clear_mon();
        err_n = 3;
        do_start(32'h0000_3000, 6'd4);
        wait_done(60, "t4b");
        check("t4b load_err", {31'd0, load_err}, 1);
        check("t4b words", {26'd0, words_loaded}, 2);
        @(negedge clk);
        check("t4b sticky err", {31'd0, load_err}, 1);
        check("t4b idle", {31'd0, busy}, 0);
        check("t4b err seen", err_seen, 3);
        log_chk(30'hC00, 2, "t4b");
        err_n = 0;

        // 5: ack+err together is an ack; start while busy ignored
        clear_mon();
        both_adr = 30'h1801;
        do_start(32'h0000_6000, 6'd4);
        check("t5 err cleared", {31'd0, load_err}, 0);
        check("t5 not ready", {31'd0, start_ready}, 0);
        start_base_adr = 32'h0000_9000;
        start_len      = 6'd1;
        start_valid    = 1'b1;
        repeat (2) @(negedge clk);
        start_valid    = 1'b0;
        wait_done(60, "t5");
        check("t5 words", {26'd0, words_loaded}, 4);
        check("t5 load_err", {31'd0, load_err}, 0);
        @(negedge clk);
        log_chk(30'h1800, 4, "t5");
        check("t5 done count", done_cnt, 1);
        read_chk(1, ram_word(30'h1801), 1'b1, "t5 buf1");
        both_adr = 30'h3FFF_FFFF;

        // 6: reset during word 5, then a clean reload
        clear_mon();
        do_start(32'h0000_4000, 6'd8);
        begin
            int k = 0;
            while (!(cyc && stb && adr == 30'h1005) && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("t6 reached word5", {31'd0, (k < 200)}, 1);
        end
        check("t6 words before", {26'd0, words_loaded}, 5);
        reset = 1'b0;
        #1;
        check("t6 cyc dropped", {31'd0, cyc | stb}, 0);
        check("t6 words cleared", {26'd0, words_loaded}, 0);
        check("t6 busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t6 no done", done_cnt, 0);
        clear_mon();
        do_start(32'h0000_5000, 6'd3);
        wait_done(40, "t6 reload");
        check("t6 reload words", {26'd0, words_loaded}, 3);
        @(negedge clk);
        log_chk(30'h1400, 3, "t6 reload");
        read_chk(2, ram_word(30'h1402), 1'b1, "t6 buf2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
